// File: rtl/int_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : riscv_types
//  Purpose  : Shared types and constants for the EXE-stage integer divider.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_types;

  // RV32M divide/remainder flavours. Bit 0 set means unsigned, bit 1 set
  // means the remainder is the requested result.
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Most negative RV32 dividend; with a divisor of -1 it overflows DIV/REM.
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  // True for the two's complement flavours (DIV, REM).
  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  // True when the remainder, not the quotient, is returned.
  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One restoring-division iteration. Shifts the next dividend bit
//             into the partial remainder and trial-subtracts the divisor.
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  // The incoming remainder is always below the divisor, so the trial
  // difference lies strictly inside +/-2^XLEN: an XLEN+1 bit result whose
  // top bit is exactly the borrow.
  logic [XLEN:0]   w_diff;
  logic            w_borrow;
  logic [XLEN-1:0] w_shifted;

  // Trial subtraction and restore selection.
  always_comb begin
    w_diff    = {i_rem, i_bit} - {1'b0, i_divisor};
    w_borrow  = w_diff[XLEN];
    w_shifted = {i_rem[XLEN-2:0], i_bit};
    o_qbit    = ~w_borrow;
    o_rem     = w_borrow ? w_shifted : w_diff[XLEN-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/int_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : int_div_unit
//  Purpose  : Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. One
//             operation in flight; result held in DONE until the pipeline
//             releases it (stall low). Divide-by-zero and signed overflow
//             complete in a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module int_div_unit
  import riscv_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  div_op_t         div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            p_last,
  output logic            busy
);

  localparam logic [XLEN-1:0] c_OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      r_state;
  logic [XLEN-1:0] r_dvd;      // dividend magnitude, consumed MSB first
  logic [XLEN-1:0] r_dsr;      // divisor magnitude
  logic [XLEN-1:0] r_rem;      // partial remainder
  logic [XLEN-1:0] r_quot;     // quotient magnitude being built
  logic [CNT_W-1:0] r_cnt;
  logic            r_fin;      // all XLEN steps done, finalise next cycle
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;

  logic            w_signed;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_rem_nxt;
  logic            w_qbit;
  logic [CNT_W:0]  w_cnt_inc;
  logic [XLEN-1:0] w_q_final;
  logic [XLEN-1:0] w_r_final;

  // Operand classification and magnitude conversion at issue.
  always_comb begin
    w_signed = op_is_signed(div_op);
    w_s1     = w_signed & rs1_data[XLEN-1];
    w_s2     = w_signed & rs2_data[XLEN-1];
    w_mag1   = w_s1 ? -rs1_data : rs1_data;
    w_mag2   = w_s2 ? -rs2_data : rs2_data;
    w_div0   = (rs2_data == '0);
    w_ovf    = w_signed && (rs1_data == c_OVF_DIVIDEND) && (rs2_data == '1);
  end

  // Iteration count with carry-out; the carry marks the final step.
  always_comb begin
    w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_q_final = r_neg_q ? -r_quot : r_quot;
    w_r_final = r_neg_r ? -r_rem  : r_rem;
  end

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[XLEN-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // Sequencer: issue, iterate, hold result; flush aborts from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
      p_last   <= 1'b0;
      busy     <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
      p_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            rd_out   <= rd_in;
            r_is_rem <= op_is_rem(div_op);
            busy     <= 1'b1;
            if (w_div0) begin
              result  <= op_is_rem(div_op) ? rs1_data : '1;
              p_last  <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_ovf) begin
              result  <= op_is_rem(div_op) ? '0 : c_OVF_DIVIDEND;
              p_last  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_dvd   <= w_mag1;
              r_dsr   <= w_mag2;
              r_rem   <= '0;
              r_quot  <= '0;
              r_cnt   <= '0;
              r_fin   <= 1'b0;
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              r_state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (r_fin) begin
            result  <= r_is_rem ? w_r_final : w_q_final;
            r_fin   <= 1'b0;
            p_last  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_rem  <= w_rem_nxt;
            r_quot <= {r_quot[XLEN-2:0], w_qbit};
            r_dvd  <= {r_dvd[XLEN-2:0], 1'b0};
            r_cnt  <= w_cnt_inc[CNT_W-1:0];
            if (w_cnt_inc[CNT_W]) begin
              r_fin <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (!stall) begin
            p_last  <= 1'b0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          p_last  <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_div_unit
//  Purpose  : Self-checking bench for int_div_unit against an arithmetic
//             reference model (directed cases plus random operations).
//  Revision : 1.0  initial release
// ============================================================================
module tb_int_div_unit;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  div_op_t     div_op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        stall;
  logic        flush;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        p_last;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .div_op   (div_op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .stall    (stall),
    .flush    (flush),
    .result   (result),
    .rd_out   (rd_out),
    .p_last   (p_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Special cases bypass iteration.
  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Issue one operation, optionally pulse start during CALC, optionally stall in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag_rd, input int stall_n, input int inj_at,
                        input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    bit          busy_ok;
    exp_res  = model(op, a, b);
    exp_lat  = is_special(op, a, b) ? 0 : 33;
    div_op   = div_op_t'(op);
    rs1_data = a;
    rs2_data = b;
    rd_in    = tag_rd;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!p_last && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == inj_at) begin
        start  = 1'b1;
        div_op = div_op_t'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    chk({tag, "_plast"}, {31'd0, p_last}, 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, tag_rd});
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    if (stall_n > 0) begin
      stall = 1'b1;
      repeat (stall_n) begin
        @(posedge clk); #1;
        chk({tag, "_hold_plast"}, {31'd0, p_last}, 32'd1);
        chk({tag, "_hold_res"}, result, exp_res);
      end
      stall = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, p_last, busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;
    reset    = 1'b1;
    start    = 1'b0;
    div_op   = OP_DIV;
    rs1_data = '0;
    rs2_data = '0;
    rd_in    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {result[15:0], 3'd0, rd_out, 6'd0, p_last, busy}, 32'd0);
    chk("reset_res", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset", {30'd0, p_last, busy}, 32'd0);

    // Directed cases
    run_op(2'd1, 32'd100, 32'd7, 5'h0A, 0, -1, "divu_100_7");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'h11, 0, -1, "rem_m7_2");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'h12, 0, -1, "div_m7_2");
    run_op(2'd1, 32'd5, 32'd0, 5'h03, 0, -1, "divu_5_0");
    run_op(2'd3, 32'd5, 32'd0, 5'h04, 0, -1, "remu_5_0");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'h1F, 0, -1, "div_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'h1E, 0, -1, "rem_ovf");
    run_op(2'd1, 32'd0, 32'd9, 5'h07, 0, -1, "divu_zero_dvd");
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'h08, 0, -1, "remu_big");
    run_op(2'd0, 32'd1234567, 32'hFFFF_FFA7, 5'h15, 4, 5, "stall_inj");

    // Flush in the middle of CALC
    div_op   = OP_DIVU;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in    = 5'h09;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_stop", {30'd0, p_last, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (p_last || busy) seen = 1'b1;
    end
    chk("flush_quiet", {31'd0, seen}, 32'd0);

    // Flush wins over a same-cycle start
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_over_start", {30'd0, p_last, busy}, 32'd0);
    run_op(2'd1, 32'd9, 32'd3, 5'h0C, 0, -1, "divu_9_3");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = DIV_OVF_DIVIDEND; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'd0;
        4:       b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), -1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
